divider_msu: RTL and testbench

Iterative SIZE-bit divider with signed, unsigned and mixed operand modes, producing quotient and remainder. It is the inverse-operation partner of the combinational multiplier_msu and uses the same `sign`/`mix` mode encoding, so one operand-decode path in the execute stage feeds both blocks. It uses a single restoring shift-subtract datapath, one quotient bit per cycle, with valid/ready handshakes on input and output.

---
 rtl/divider_msu_if.sv | 27 ++
 rtl/divider_msu.sv | 202 ++++++++++++++++++++
 tb/tb_divider_msu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/divider_msu_if.sv
// Request/response bundle for divider_msu: operand/mode handshake in, quotient/remainder handshake out.
interface divider_msu_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            sign;
  logic            mix;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] q;
  logic [SIZE-1:0] r;
  logic            dz;
  logic            ovf;

  modport master (
    output in_valid, a, b, sign, mix, out_ready,
    input  in_ready, out_valid, q, r, dz, ovf
  );

  modport slave (
    input  in_valid, a, b, sign, mix, out_ready,
    output in_ready, out_valid, q, r, dz, ovf
  );
endinterface

// File: rtl/divider_msu.sv
// Iterative restoring divider (signed / unsigned / mixed), one quotient bit per cycle.
// Optional DIVIDER_EARLY_OUT_EN lets trivial cases (b=0, overflow, |a|<|b|) skip the iteration phase.
module divider_msu #(
  parameter int SIZE = 32
) (
  input  logic         clk,
  input  logic         rst,
  divider_msu_if.slave bus
);
  localparam int CW = $clog2(SIZE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [SIZE-1:0] a_r, b_r, dvd_r, dvs_r, rem_r, q_r, r_r;
  logic            sign_r, mix_r, q_neg_r, r_neg_r, dz_flag_r, ovf_flag_r;
  logic            in_ready_r, out_valid_r, dz_r, ovf_r;
  logic            a_neg_s, b_neg_s, dz_s, ovf_s;
  logic [SIZE-1:0] a_mag_s, b_mag_s, q_fix_s, r_fix_s;
  logic [SIZE:0]   shifted_s, diff_s;
`ifdef DIVIDER_EARLY_OUT_EN
  logic            small_r;
`endif

  // Operand decode: magnitudes, signs and special-case detection from the captured request
  always_comb begin
    a_neg_s = (sign_r | mix_r) & a_r[SIZE-1];
    b_neg_s = sign_r & b_r[SIZE-1];
    if (a_neg_s) begin
      a_mag_s = -a_r;
    end else begin
      a_mag_s = a_r;
    end
    if (b_neg_s) begin
      b_mag_s = -b_r;
    end else begin
      b_mag_s = b_r;
    end
    dz_s      = (b_r == {SIZE{1'b0}});
    ovf_s     = sign_r & (a_r == {1'b1, {(SIZE-1){1'b0}}}) & (b_r == {SIZE{1'b1}});
    // Bit SIZE of the difference is the borrow: set means the trial subtract went negative
    shifted_s = {rem_r, dvd_r[SIZE-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
  end

  // Final result selection: special cases override the sign-corrected datapath result
  always_comb begin
    if (dz_flag_r) begin
      q_fix_s = {SIZE{1'b1}};
      r_fix_s = a_r;
    end else if (ovf_flag_r) begin
      q_fix_s = a_r;
      r_fix_s = {SIZE{1'b0}};
`ifdef DIVIDER_EARLY_OUT_EN
    end else if (small_r) begin
      q_fix_s = {SIZE{1'b0}};
      r_fix_s = a_r;
`endif
    end else begin
      if (q_neg_r) begin
        q_fix_s = -dvd_r;
      end else begin
        q_fix_s = dvd_r;
      end
      if (r_neg_r) begin
        r_fix_s = -rem_r;
      end else begin
        r_fix_s = rem_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = PREP;
        end else begin
          state_s = IDLE;
        end
      end
      PREP: begin
`ifdef DIVIDER_EARLY_OUT_EN
        if (dz_s | ovf_s | (a_mag_s < b_mag_s)) begin
          state_s = FIX;
        end else begin
          state_s = ITER;
        end
`else
        state_s = ITER;
`endif
      end
      ITER: begin
        if (cnt_r == CW'(SIZE - 1)) begin
          state_s = FIX;
        end else begin
          state_s = ITER;
        end
      end
      FIX:  state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: capture, prepare, shift-subtract iterations and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= {SIZE{1'b0}};
      b_r        <= {SIZE{1'b0}};
      sign_r     <= 1'b0;
      mix_r      <= 1'b0;
      dvd_r      <= {SIZE{1'b0}};
      dvs_r      <= {SIZE{1'b0}};
      rem_r      <= {SIZE{1'b0}};
      cnt_r      <= {CW{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      dz_flag_r  <= 1'b0;
      ovf_flag_r <= 1'b0;
      q_r        <= {SIZE{1'b0}};
      r_r        <= {SIZE{1'b0}};
      dz_r       <= 1'b0;
      ovf_r      <= 1'b0;
`ifdef DIVIDER_EARLY_OUT_EN
      small_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sign_r <= bus.sign;
            mix_r  <= bus.mix;
          end
        end
        PREP: begin
          dvd_r      <= a_mag_s;
          dvs_r      <= b_mag_s;
          rem_r      <= {SIZE{1'b0}};
          cnt_r      <= {CW{1'b0}};
          q_neg_r    <= a_neg_s ^ b_neg_s;
          r_neg_r    <= a_neg_s;
          dz_flag_r  <= dz_s;
          ovf_flag_r <= ovf_s;
`ifdef DIVIDER_EARLY_OUT_EN
          small_r    <= (a_mag_s < b_mag_s);
`endif
        end
        ITER: begin
          rem_r <= diff_s[SIZE] ? shifted_s[SIZE-1:0] : diff_s[SIZE-1:0];
          dvd_r <= {dvd_r[SIZE-2:0], ~diff_s[SIZE]};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          q_r   <= q_fix_s;
          r_r   <= r_fix_s;
          dz_r  <= dz_flag_r;
          ovf_r <= ovf_flag_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
  assign bus.dz        = dz_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_divider_msu.sv
// Self-checking bench for divider_msu: directed and random requests against an arithmetic reference model.
module tb_divider_msu;
  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  divider_msu_if #(.SIZE(SIZE)) bus ();

  divider_msu #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the mode deciding how bits are interpreted
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms, input logic mm,
                       output logic [31:0] eq, output logic [31:0] er,
                       output logic edz, output logic eovf, output int elat);
    longint av, bv, qv, rv, aa, ab;
    logic   trivial;
    av   = (ms || mm) ? longint'($signed(ma)) : longint'(ma);
    bv   = ms ? longint'($signed(mb)) : longint'(mb);
    edz  = 1'b0;
    eovf = 1'b0;
    if (bv == 0) begin
      eq  = 32'hFFFF_FFFF;
      er  = ma;
      edz = 1'b1;
    end else if (ms && av == -longint'(64'sd2147483648) && bv == -1) begin
      eq   = ma;
      er   = 32'h0;
      eovf = 1'b1;
    end else begin
      qv = av / bv;
      rv = av % bv;
      eq = qv[31:0];
      er = rv[31:0];
    end
    aa = (av < 0) ? -av : av;
    ab = (bv < 0) ? -bv : bv;
    trivial = edz || eovf || (aa < ab);
`ifdef DIVIDER_EARLY_OUT_EN
    elat = trivial ? 3 : SIZE + 3;
`else
    elat = SIZE + 3;
`endif
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the DONE->IDLE edge
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts, input logic tm,
                        input int stall);
    logic [31:0] eq, er;
    logic        edz, eovf;
    int          elat, lat;
    logic [31:0] q_hold, r_hold;
    model(ta, tbv, ts, tm, eq, er, edz, eovf, elat);
    check("in_ready_idle", bus.in_ready, 1);
    bus.a        = ta;
    bus.b        = tbv;
    bus.sign     = ts;
    bus.mix      = tm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.sign     = 1'($urandom);
    bus.mix      = 1'($urandom);
    check("in_ready_fall", bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, elat);
    check("q", bus.q, eq);
    check("r", bus.r, er);
    check("dz", bus.dz, edz);
    check("ovf", bus.ovf, eovf);
    q_hold = bus.q;
    r_hold = bus.r;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_ready", bus.in_ready, 0);
      check("stall_q", bus.q, q_hold);
      check("stall_r", bus.r, r_hold);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs, rm;
    int          kind;

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    bus.sign      = 1'b0;
    bus.mix       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_dz", bus.dz, 0);
    check("rst_ovf", bus.ovf, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("dropped_req", bus.in_ready, 1);

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
    run_op(32'hFFFF_FF9C, 32'd3, 1'b0, 1'b1, 2);
    run_op(32'hFFFF_FFF9, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0, 1'b1, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0, 1'b0, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    run_op(32'd5, 32'd9, 1'b0, 1'b0, 0);
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 10);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      ra   = $urandom;
      rb   = $urandom;
      rs   = 1'($urandom);
      rm   = 1'($urandom);
      case (kind)
        0: rb = 32'h0;
        1: begin ra = $urandom_range(0, 50); rb = $urandom_range(51, 1000); end
        2: rb = $urandom_range(1, 255);
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: begin end
      endcase
      run_op(ra, rb, rs, rm, $urandom_range(0, 3));
    end

    // Reset in the middle of an operation
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    bus.sign     = 1'b0;
    bus.mix      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_q", bus.q, 0);
    check("mid_rst_r", bus.r, 0);
    check("mid_rst_dz", bus.dz, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
